// File: rtl/sn_stream_decoder_if.sv
// Stream-in / result-out bundle for the SN stream decoder.
// The master side drives the bitstream and controls; the slave side is the decoder.
interface sn_stream_decoder_if #(
    parameter int unsigned WIN_LOG2 = 4
);
    logic                sn_bit;
    logic                sn_valid;
    logic                start;
    logic                abort;
    logic                cont;
    logic                result_ack;
    logic [WIN_LOG2:0]   result;
    logic [WIN_LOG2+1:0] result_bip;
    logic                result_valid;
    logic                busy;
    logic                overrun;

    modport master (
        output sn_bit, sn_valid, start, abort, cont, result_ack,
        input  result, result_bip, result_valid, busy, overrun
    );

    modport slave (
        input  sn_bit, sn_valid, start, abort, cont, result_ack,
        output result, result_bip, result_valid, busy, overrun
    );
endinterface

// File: rtl/sn_stream_decoder.sv
// SN link receiver: counts ones over windows of 2**WIN_LOG2 valid bits and publishes
// unipolar count and bipolar value through a valid/ack result port.
module sn_stream_decoder #(
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sn_stream_decoder_if.slave sn_if
);
    localparam int unsigned WIN = 1 << WIN_LOG2;
    localparam int unsigned CW  = WIN_LOG2 + 1;
    localparam int unsigned BW  = WIN_LOG2 + 2;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    logic [0:0]          r_state,   w_state_nxt;
    logic [WIN_LOG2-1:0] r_bitcnt,  w_bitcnt_nxt;
    logic [CW-1:0]       r_ones,    w_ones_nxt;
    logic [CW-1:0]       r_result,  w_result_nxt;
    logic [BW-1:0]       r_bip,     w_bip_nxt;
    logic                r_valid,   w_valid_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_overrun, w_overrun_nxt;

    logic [CW-1:0]       w_sum;
    logic [BW-1:0]       w_sum_bip;
    logic                w_last;

    // Count including the current bit; width CW holds WIN exactly, so no wrap.
    assign w_sum     = r_ones + CW'(sn_if.sn_bit);
    assign w_sum_bip = BW'({w_sum, 1'b0}) - BW'(WIN);
    assign w_last    = sn_if.sn_valid && (r_bitcnt == WIN_LOG2'(WIN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= '0;
            r_ones    <= '0;
            r_result  <= '0;
            r_bip     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_ones    <= w_ones_nxt;
            r_result  <= w_result_nxt;
            r_bip     <= w_bip_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bitcnt_nxt  = r_bitcnt;
        w_ones_nxt    = r_ones;
        w_result_nxt  = r_result;
        w_bip_nxt     = r_bip;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;

        // Ack first; a publish in the same cycle re-asserts valid below.
        if (r_valid && sn_if.result_ack) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (sn_if.start && !sn_if.abort) begin
                    w_state_nxt   = S_ACCUM;
                    w_bitcnt_nxt  = '0;
                    w_ones_nxt    = '0;
                    w_overrun_nxt = 1'b0;
                end
            end
            S_ACCUM: begin
                if (sn_if.abort) begin
                    w_state_nxt  = S_IDLE;
                    w_bitcnt_nxt = '0;
                    w_ones_nxt   = '0;
                end else if (w_last) begin
                    w_result_nxt = w_sum;
                    w_bip_nxt    = w_sum_bip;
                    w_valid_nxt  = 1'b1;
                    if (r_valid && !sn_if.result_ack) begin
                        w_overrun_nxt = 1'b1;
                    end
                    w_bitcnt_nxt = '0;
                    w_ones_nxt   = '0;
                    w_state_nxt  = sn_if.cont ? S_ACCUM : S_IDLE;
                end else if (sn_if.sn_valid) begin
                    w_bitcnt_nxt = r_bitcnt + WIN_LOG2'(1);
                    w_ones_nxt   = w_sum;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_ACCUM);
    end

    assign sn_if.result       = r_result;
    assign sn_if.result_bip   = r_bip;
    assign sn_if.result_valid = r_valid;
    assign sn_if.busy         = r_busy;
    assign sn_if.overrun      = r_overrun;
endmodule
